// File: rtl/bram_read_streamer.sv
// rtl/bram_read_streamer.sv - BRAM read streamer with credit-limited FWFT output FIFO
// Issues length*max(repeat_count,1) reads, possibly over several passes, and streams the data in order.
module bram_read_streamer #(
   parameter int WIDTH           = 8,
   parameter int LOG2_DEPTH      = 5,
   parameter int LOG2_FIFO_DEPTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LOG2_DEPTH-1:0] start_addr,
   input  logic [LOG2_DEPTH:0]   length,
   input  logic [15:0]           repeat_count,
   output logic                  busy,
   output logic                  done,
   output logic                  re,
   output logic [LOG2_DEPTH-1:0] raddr,
   output logic [1:0]            rfifobram,
   input  logic                  rvalid,
   input  logic [WIDTH-1:0]      rdata,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   input  logic                  out_ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   localparam int FIFO_DEPTH = 1 << LOG2_FIFO_DEPTH;
   localparam int CW         = LOG2_FIFO_DEPTH + 1;

   state_t                     state_q, state_d;
   logic [LOG2_DEPTH-1:0]      addr_q, base_q;
   logic [LOG2_DEPTH:0]        len_q, word_q;
   logic [15:0]                reps_q, pass_q;
   logic [CW-1:0]              outstanding_q, fifo_count_q;
   logic [LOG2_FIFO_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0]           mem [FIFO_DEPTH];
   logic [CW:0]                credit_sum;
   logic                       credit_ok, last_in_pass, last_pass;
   logic                       accept, push, pop, fifo_empty, fifo_full;

   // Every issued read must have a guaranteed FIFO slot, whatever the read latency.
   assign credit_sum   = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
   assign credit_ok    = credit_sum < (CW+1)'(FIFO_DEPTH);
   assign last_in_pass = word_q == len_q - (LOG2_DEPTH+1)'(1);
   assign last_pass    = pass_q == reps_q - 16'd1;

   assign fifo_empty = fifo_count_q == '0;
   assign fifo_full  = fifo_count_q == CW'(FIFO_DEPTH);
   assign accept     = rvalid && (outstanding_q != '0);
   assign push       = accept;
   assign pop        = !fifo_empty && out_ready;

   assign out_valid = !fifo_empty;
   assign out_data  = mem[rd_ptr_q];
   assign raddr     = addr_q;
   assign rfifobram = 2'b01;
   assign busy      = state_q != IDLE;

   always_comb begin
      state_d = state_q;
      re      = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = (length == '0) ? DRAIN : ISSUE;
         end
         ISSUE: begin
            if (credit_ok) begin
               re = 1'b1;
               if (last_in_pass && last_pass) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (outstanding_q == '0 && fifo_empty) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         base_q  <= '0;
         len_q   <= '0;
         word_q  <= '0;
         reps_q  <= 16'd1;
         pass_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start) begin
            base_q <= start_addr;
            addr_q <= start_addr;
            len_q  <= length;
            reps_q <= (repeat_count == 16'd0) ? 16'd1 : repeat_count;
            word_q <= '0;
            pass_q <= '0;
         end else if (re) begin
            if (last_in_pass) begin
               word_q <= '0;
               pass_q <= pass_q + 16'd1;
               addr_q <= base_q;
            end else begin
               word_q <= word_q + (LOG2_DEPTH+1)'(1);
               addr_q <= addr_q + LOG2_DEPTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding_q <= '0;
      end else begin
         case ({re, accept})
            2'b10:   outstanding_q <= outstanding_q + CW'(1);
            2'b01:   outstanding_q <= outstanding_q - CW'(1);
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + LOG2_FIFO_DEPTH'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + LOG2_FIFO_DEPTH'(1);
         case ({push, pop})
            2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
            2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
            default: fifo_count_q <= fifo_count_q;
         endcase
      end
   end

   // The credit rule makes this unreachable; it guards against future edits.
   always_ff @(posedge clk) begin
      if (!reset) assert (!(push && fifo_full && !pop));
   end

endmodule

// File: doc/bram_read_streamer.md
BRAM_READ_STREAMER -- requirements
Module: bram_read_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter LOG2_DEPTH, default 5, BRAM address width.
REQ-003 SHALL have parameter LOG2_FIFO_DEPTH, default 3, output FIFO depth is 2**LOG2_FIFO_DEPTH.
REQ-004 SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle pulse that launches a transfer.
REQ-008 start_addr  input  LOG2_DEPTH  first BRAM address, sampled on an accepted start.
REQ-009 length  input  LOG2_DEPTH+1  words per pass, sampled on an accepted start.
REQ-010 repeat_count  input  16  number of passes, sampled on an accepted start.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse at transfer completion.
REQ-013 re  output  1  read enable to the replicated-BRAM read channel.
REQ-014 raddr  output  LOG2_DEPTH  read address.
REQ-015 rfifobram  output  2  region select, constant 2'b01 (BRAM).
REQ-016 rvalid  input  1  read data valid from the read channel.
REQ-017 rdata  input  WIDTH  read data.
REQ-018 out_valid  output  1  output stream valid.
REQ-019 out_data  output  WIDTH  output stream data.
REQ-020 out_ready  input  1  output stream ready (backpressure).

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, DRAIN: IDLE->ISSUE on start; ISSUE->DRAIN when the last read is issued; DRAIN->IDLE when outstanding==0 and FIFO empty, with done=1 in that transition cycle.
REQ-022 SHALL ignore start when not in IDLE.
REQ-023 SHALL treat repeat_count==0 as 1; total reads = length*max(repeat_count,1).
REQ-024 SHALL, when length==0, go IDLE->DRAIN with no reads and pulse done the cycle after start.
REQ-025 SHALL issue re=1 in ISSUE only when outstanding+fifo_count < 2**LOG2_FIFO_DEPTH (credit rule), at most one read per cycle.
REQ-026 SHALL increment raddr modulo 2**LOG2_DEPTH per issued read (wrap 31->0 at default), and rewind to start_addr at each pass boundary.
REQ-027 SHALL keep outstanding counter: +1 on issue, -1 on accepted rvalid, both in one cycle = unchanged.
REQ-028 SHALL not depend on a fixed read latency; data is captured only on rvalid.
REQ-029 SHALL drop rvalid when outstanding==0 (stray data after reset).
REQ-030 SHALL write rdata into the FIFO on accepted rvalid; FIFO overflow is impossible by REQ-025 and SHALL be flagged by a simulation assertion.
REQ-031 SHALL present the FIFO as first-word-fall-through: out_valid = !empty, out_data = head, pop on out_valid&&out_ready; simultaneous push and pop on a full or empty FIFO SHALL be handled correctly.
REQ-032 SHALL preserve word order: output order equals address issue order.
REQ-033 SHALL drive re=0 outside ISSUE; busy=1 in ISSUE and DRAIN.

Reset
REQ-034 SHALL, on reset, set state=IDLE, busy=0, done=0, re=0, raddr=0, outstanding=0, FIFO empty (out_valid=0), pass counter=0.
REQ-035 SHALL, on reset mid-operation, abandon the transfer without a done pulse; the next start SHALL behave as from power-up.

Verification
REQ-036 BRAM[0..7]=0..7, start_addr=0, length=8, repeat=1, out_ready=1 -> out_data 0..7 in order, one done pulse, exactly 8 re pulses.
REQ-037 start_addr=30, length=4, repeat=2 -> raddr 30,31,0,1,30,31,0,1; output matches those contents.
REQ-038 length=16, out_ready=0 for 20 cycles then 1 -> re stops after 8 outstanding+buffered; no data lost; all 16 words delivered in order.
REQ-039 length=0 -> done exactly 1 cycle after start, no re, no out_valid.
REQ-040 reset asserted 3 cycles after start with reads in flight -> busy=0, out_valid=0, late rvalid dropped, no done; a following start with length=2 delivers exactly 2 words.
REQ-041 start pulse during busy -> ignored; original transfer output unchanged.
